// File: rtl/mac_dot_sequencer_pkg.sv
// Shared definitions for the FP16 MAC dot-product sequencer: FSM encodings and FP16 constants.
package mac_dot_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StStream = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4
  } seq_state_e;

  localparam logic [15:0] Fp16Zero  = 16'h0000;
  localparam logic [15:0] Fp16Half  = 16'h3800;
  localparam logic [15:0] Fp16One   = 16'h3C00;
  localparam logic [15:0] Fp16Two   = 16'h4000;
  localparam logic [15:0] Fp16Three = 16'h4200;
  localparam logic [15:0] Fp16NegOne = 16'hBC00;

  localparam int unsigned DefaultMacLat = 3;

endpackage

// File: rtl/mac_seq_counter.sv
// Loadable down-counter that saturates at zero; flags zero and one for the sequencer FSM.
module mac_seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         Asynch_Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  // Load has priority; decrement is ignored at zero so the count never wraps.
  always_ff @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job controller for a pipelined FP16 MAC: clear, stream N pairs, drain, capture, hand out.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = DefaultMacLat
) (
  input  logic             clk,
  input  logic             Asynch_Reset,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_numA,
  output logic [15:0]      mac_numB,
  output logic             mac_activate,
  output logic             mac_clr,
  input  logic [15:0]      mac_result,
  output logic [15:0]      result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [LEN_W-1:0] DrainInit = LEN_W'(MAC_LAT - 1);

  seq_state_e state;

  logic hs;
  logic pair_load, pair_dec, pair_zero, pair_last;
  logic drain_load, drain_dec, drain_zero, drain_last;

  assign hs         = in_valid & in_ready;
  assign pair_load  = (state == StIdle) & start;
  assign pair_dec   = (state == StStream) & hs;
  assign drain_load = pair_dec & pair_last;
  assign drain_dec  = (state == StDrain);

  mac_seq_counter #(
    .W (LEN_W)
  ) u_pair_cnt (
    .clk          (clk),
    .Asynch_Reset (Asynch_Reset),
    .load         (pair_load),
    .load_val     (vec_len),
    .dec          (pair_dec),
    .zero         (pair_zero),
    .last         (pair_last)
  );

  mac_seq_counter #(
    .W (LEN_W)
  ) u_drain_cnt (
    .clk          (clk),
    .Asynch_Reset (Asynch_Reset),
    .load         (drain_load),
    .load_val     (DrainInit),
    .dec          (drain_dec),
    .zero         (drain_zero),
    .last         (drain_last)
  );

  // drain_last is not needed: the drain phase ends on the zero flag.
  logic drain_last_unused;
  assign drain_last_unused = drain_last;

  // Job FSM with all outputs registered; mac_clr defaults low so it is a clean 1-cycle pulse.
  always_ff @(posedge clk or posedge Asynch_Reset) begin
    if (Asynch_Reset) begin
      state        <= StIdle;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      mac_numA     <= Fp16Zero;
      mac_numB     <= Fp16Zero;
      mac_activate <= 1'b0;
      mac_clr      <= 1'b0;
      result       <= Fp16Zero;
      result_valid <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            state <= StClear;
            busy  <= 1'b1;
          end
        end
        StClear: begin
          mac_clr      <= 1'b1;
          mac_activate <= 1'b0;
          if (pair_zero) begin
            state  <= StDone;
            result <= Fp16Zero;
          end else begin
            state    <= StStream;
            in_ready <= 1'b1;
          end
        end
        StStream: begin
          if (hs) begin
            mac_numA     <= in_a;
            mac_numB     <= in_b;
            mac_activate <= 1'b1;
            if (pair_last) begin
              state    <= StDrain;
              in_ready <= 1'b0;
            end
          end else begin
            // Freeze the MAC pipeline rather than inject a bubble.
            mac_activate <= 1'b0;
          end
        end
        StDrain: begin
          if (!drain_zero) begin
            mac_numA     <= Fp16Zero;
            mac_numB     <= Fp16Zero;
            mac_activate <= 1'b1;
          end else if (mac_activate) begin
            // Last drain operand is sampled on this edge; sum is readable next cycle.
            mac_activate <= 1'b0;
          end else begin
            result       <= mac_result;
            result_valid <= 1'b1;
            state        <= StDone;
          end
        end
        StDone: begin
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural 3-stage FP16 MAC attached.
module tb_mac_dot_sequencer;
  import mac_dot_sequencer_pkg::*;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned MAC_LAT = 3;
  localparam logic [15:0] OPS [6] = '{Fp16Zero, Fp16Half, Fp16One, Fp16Two, Fp16Three,
                                      Fp16NegOne};

  logic             clk, Asynch_Reset, start, busy, in_valid, in_ready;
  logic             mac_activate, mac_clr, result_valid, result_ready;
  logic [LEN_W-1:0] vec_len;
  logic [15:0]      in_a, in_b, mac_numA, mac_numB, mac_result, result;

  typedef struct packed {
    logic [15:0] res;
    logic [31:0] acts;
  } exp_t;

  int          tests = 0;
  int          failed = 0;
  int          hold_err = 0;
  int          overlap_err = 0;
  exp_t        sb[$];
  logic [15:0] job_a[$];
  logic [15:0] job_b[$];
  int          vpat[$];

  mac_dot_sequencer #(
    .LEN_W   (LEN_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk          (clk),
    .Asynch_Reset (Asynch_Reset),
    .start        (start),
    .vec_len      (vec_len),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mac_numA     (mac_numA),
    .mac_numB     (mac_numB),
    .mac_activate (mac_activate),
    .mac_clr      (mac_clr),
    .mac_result   (mac_result),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    if (e != 0) m = m + 1.0;
    else e = 1;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  // Exact for the small dyadic values this bench generates.
  function automatic logic [15:0] r2fp(input real v);
    logic       s;
    int         e;
    real        m;
    logic [4:0] ef;
    logic [9:0] f;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    ef = 5'(e);
    f  = 10'(int'((m - 1.0) * 1024.0));
    return {s, ef, f};
  endfunction

  // Behavioural MAC: product, align, accumulate stages; advances only on activate.
  real p1 = 0.0, p2 = 0.0, acc = 0.0;
  wire mac_rst = mac_clr | Asynch_Reset;
  always @(posedge clk or posedge mac_rst) begin
    if (mac_rst) begin
      p1 <= 0.0; p2 <= 0.0; acc <= 0.0;
    end else if (mac_activate) begin
      acc <= acc + p2;
      p2  <= p1;
      p1  <= fp2r(mac_numA) * fp2r(mac_numB);
    end
  end
  always_comb mac_result = r2fp(acc);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: tracks MAC control per job and checks each result handshake against the queue.
  initial begin
    int          act_cnt;
    int          clr_cnt;
    logic [15:0] prev_a, prev_b;
    exp_t        e;
    act_cnt = 0; clr_cnt = 0; prev_a = '0; prev_b = '0;
    forever begin
      @(negedge clk);
      if (Asynch_Reset) begin
        act_cnt = 0; clr_cnt = 0; prev_a = '0; prev_b = '0;
      end else begin
        if (mac_clr && mac_activate) overlap_err++;
        if (!mac_activate && (mac_numA !== prev_a || mac_numB !== prev_b)) hold_err++;
        prev_a = mac_numA;
        prev_b = mac_numB;
        if (mac_clr) begin act_cnt = 0; clr_cnt++; end
        if (mac_activate) act_cnt++;
        if (result_valid && result_ready) begin
          if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_result: got %h with no job outstanding", result);
          end else begin
            e = sb.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("activate_count", 64'(act_cnt), 64'(e.acts));
            chk("clr_pulses", 64'(clr_cnt), 64'd1);
          end
          clr_cnt = 0;
        end
      end
    end
  end

  task automatic clear_job();
    job_a.delete();
    job_b.delete();
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    job_a.push_back(a);
    job_b.push_back(b);
  endtask

  task automatic run_job(input int n, input int gap_pct, input int rdy_wait, input bit pulse_st);
    real         sum;
    exp_t        e;
    int          cyc, idx, exp_lat;
    bit          stable, had_pat;
    logic [15:0] r0;
    sum = 0.0;
    for (int i = 0; i < n; i++) sum += fp2r(job_a[i]) * fp2r(job_b[i]);
    e.res  = r2fp(sum);
    e.acts = (n > 0) ? 32'(n + MAC_LAT - 1) : 32'd0;
    sb.push_back(e);
    exp_lat = (n == 0) ? 2 : n + MAC_LAT + 2;
    had_pat = (vpat.size() > 0);
    start   = 1'b1;
    vec_len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    idx = 0;
    while (!result_valid && cyc < 300) begin
      in_valid = 1'b0;
      if (idx < n) begin
        if (vpat.size() > 0) in_valid = (vpat.pop_front() != 0);
        else in_valid = ($urandom_range(99) >= gap_pct);
        in_a = job_a[idx];
        in_b = job_b[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    vpat.delete();
    if (!result_valid) begin
      tests++;
      failed++;
      $display("FAIL result_timeout: no result_valid after %0d cycles, required one", cyc);
      void'(sb.pop_back());
      return;
    end
    if (gap_pct == 0 && !had_pat) chk("latency", 64'(cyc), 64'(exp_lat));
    r0     = result;
    stable = 1'b1;
    for (int k = 0; k < rdy_wait; k++) begin
      if (pulse_st && k == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!(result_valid && busy && result == r0)) stable = 1'b0;
    end
    if (rdy_wait > 0) chk("done_hold_stable", 64'(stable), 64'd1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("idle_after_take", 64'({busy, result_valid}), 64'd0);
    @(posedge clk); #1;
    chk("start_not_queued", 64'(busy), 64'd0);
  endtask

  initial begin
    int hs, cyc, n;
    Asynch_Reset = 1'b1;
    start = 1'b0; vec_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({busy, in_ready, mac_activate, mac_clr, result_valid,
                              mac_numA, mac_numB, result}), 64'd0);
    Asynch_Reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'({busy, in_ready, result_valid}), 64'd0);

    // 1*2 + 2*3 = 8.0
    clear_job(); push_pair(Fp16One, Fp16Two); push_pair(Fp16Two, Fp16Three);
    run_job(2, 0, 0, 1'b0);

    // Empty job: clear pulse only.
    clear_job();
    run_job(0, 0, 0, 1'b0);

    // Operand gaps: pipeline freezes, result unaffected.
    clear_job();
    for (int i = 0; i < 3; i++) push_pair(Fp16One, Fp16One);
    vpat = {1, 0, 0, 1, 0, 1};
    run_job(3, 0, 0, 1'b0);

    // Consumer stalls with a stray start in DONE.
    clear_job(); push_pair(Fp16Two, Fp16Two); push_pair(Fp16One, Fp16One);
    run_job(2, 0, 10, 1'b1);

    // Back-to-back jobs must not carry the accumulator over.
    clear_job(); push_pair(Fp16Two, Fp16Two);
    run_job(1, 0, 0, 1'b0);
    clear_job(); push_pair(Fp16One, Fp16Three);
    run_job(1, 0, 0, 1'b0);

    // Reset mid-stream after the first of four pairs.
    start = 1'b1; vec_len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_a = Fp16One; in_b = Fp16One;
    hs = 0; cyc = 0;
    while (hs == 0 && cyc < 10) begin
      @(negedge clk);
      if (in_ready) hs = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("reset_test_handshake", 64'(hs), 64'd1);
    chk("reset_test_active", 64'(mac_activate), 64'd1);
    in_valid = 1'b0;
    #1 Asynch_Reset = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({busy, in_ready, mac_activate, mac_clr, result_valid,
                                    mac_numA, mac_numB, result}), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    Asynch_Reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_async_reset", 64'({busy, result_valid}), 64'd0);
    clear_job(); push_pair(Fp16One, Fp16One);
    run_job(1, 0, 0, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 20; j++) begin
      clear_job();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) push_pair(OPS[$urandom_range(0, 5)], OPS[$urandom_range(0, 5)]);
      run_job(n, (j % 2 == 0) ? 0 : 35, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("operand_hold_violations", 64'(hold_err), 64'd0);
    chk("clr_activate_overlap", 64'(overlap_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
